// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
// Word width and output buffer depth are fixed here and never overridden locally.
package fifo_stream_reader_pkg;

    localparam int FIFO_WIDTH   = 16;
    localparam int RD_BUF_DEPTH = 3;
    localparam int PTR_WIDTH    = 2;
    localparam int OCC_WIDTH    = 2;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
    typedef logic [PTR_WIDTH-1:0]  buf_ptr_t;
    typedef logic [OCC_WIDTH-1:0]  buf_occ_t;

    localparam buf_occ_t OCC_FULL = buf_occ_t'(RD_BUF_DEPTH);

    // Pointers walk 0,1,2,0,... since the buffer depth is not a power of two.
    function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
        buf_ptr_t nxt;
        if (p == buf_ptr_t'(RD_BUF_DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = p + buf_ptr_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Downstream valid/ready word stream produced by the drain engine.
// master drives data/valid, slave drives ready.
interface fifo_stream_reader_if;
    import fifo_stream_reader_pkg::*;

    fifo_word_t m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/fifo_stream_reader_rd_skid_buf.sv
// Three-entry circular output buffer sitting between FIFO read data and the stream.
// Head is forced to zero while empty so the stream data bus is quiet when idle.
module fifo_stream_reader_rd_skid_buf
    import fifo_stream_reader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  fifo_word_t push_data_i,
    input  logic       pop_i,
    output fifo_word_t head_o,
    output buf_occ_t   occ_o
);

    fifo_word_t mem_q [RD_BUF_DEPTH];
    buf_ptr_t   wr_ptr_q, wr_ptr_d;
    buf_ptr_t   rd_ptr_q, rd_ptr_d;
    buf_occ_t   occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + buf_occ_t'(1);
            2'b01:   occ_d = occ_q - buf_occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: it is only observed through occ_q.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign occ_o  = occ_q;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && (occ_q == OCC_FULL)));

    a_no_underrun : assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && (occ_q == '0)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads, absorbs the one-cycle read latency,
// and streams words downstream at one per clock with a delivered-word count and sticky underflow flag.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  fifo_word_t           fifo_data_out_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_underflow_i,
    output logic                 fifo_rd_en_o,
    fifo_stream_reader_if.master m_if,
    output logic [CNT_WIDTH-1:0] words_read_o,
    output logic                 underflow_err_o,
    input  logic                 clr_err_i
);

    logic                 inflight_q;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    buf_occ_t             occ;
    fifo_word_t           head;
    logic [2:0]           pending;
    logic                 capture;
    logic                 push;
    logic                 pop;

    // Reserve a buffer slot for every read in flight so a returning word always fits.
    assign pending      = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_rd_en_o = !rst_i && en_i && !fifo_empty_i && (pending < 3'(RD_BUF_DEPTH));

    assign capture = inflight_q;
    assign push    = capture && !fifo_underflow_i;
    assign pop     = m_if.m_valid && m_if.m_ready;

    fifo_stream_reader_rd_skid_buf u_rd_skid_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (fifo_data_out_i),
        .pop_i       (pop),
        .head_o      (head),
        .occ_o       (occ)
    );

    assign m_if.m_valid = (occ != '0);
    assign m_if.m_data  = head;

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (capture && fifo_underflow_i) begin
            err_d = 1'b1;
        end else if (clr_err_i) begin
            err_d = 1'b0;
        end
        if (pop) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= fifo_rd_en_o;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign words_read_o    = cnt_q;
    assign underflow_err_o = err_q;

    a_capture_fits : assert property (@(posedge clk_i) disable iff (rst_i)
        !(capture && (occ == OCC_FULL)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model, per-cycle vector table,
// scoreboard of expected stream words, and hand sequences for the multi-cycle cases.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr_err;
    logic             force_uf;
    logic             fifo_empty = 1'b1;
    logic             fifo_uf_q  = 1'b0;
    fifo_word_t       fifo_dout  = '0;
    logic             fifo_underflow;
    logic             fifo_rd_en;
    logic [CNT_W-1:0] words_read;
    logic             underflow_err;

    fifo_stream_reader_if s_if ();

    always #5 clk = ~clk;

    assign fifo_underflow = fifo_uf_q | force_uf;

    fifo_stream_reader #(.CNT_WIDTH(CNT_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_i             (en),
        .fifo_data_out_i  (fifo_dout),
        .fifo_empty_i     (fifo_empty),
        .fifo_underflow_i (fifo_underflow),
        .fifo_rd_en_o     (fifo_rd_en),
        .m_if             (s_if),
        .words_read_o     (words_read),
        .underflow_err_o  (underflow_err),
        .clr_err_i        (clr_err)
    );

    fifo_word_t       fifo_q [$];
    fifo_word_t       exp_q  [$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] cnt_exp  = '0;
    logic             stall_prev = 1'b0;
    fifo_word_t       data_prev  = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // FIFO model: one-cycle read latency, empty flag registered after the edge.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() > 0) begin
                fifo_dout <= fifo_q.pop_front();
                fifo_uf_q <= 1'b0;
            end else begin
                fifo_uf_q <= 1'b1;
            end
        end else begin
            fifo_uf_q <= 1'b0;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (rst) begin
            cnt_exp    = '0;
            stall_prev = 1'b0;
        end else begin
            check("words_read", 32'(words_read), 32'(cnt_exp));
            if (stall_prev) begin
                check("hold_valid", 32'(s_if.m_valid), 32'd1);
                check("hold_data", 32'(s_if.m_data), 32'(data_prev));
            end
            if (s_if.m_valid && s_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(s_if.m_data), 32'hFFFF_FFFF);
                end else begin
                    check("stream_data", 32'(s_if.m_data), 32'(exp_q.pop_front()));
                end
                cnt_exp = cnt_exp + CNT_W'(1);
            end
            stall_prev = s_if.m_valid && !s_if.m_ready;
            data_prev  = s_if.m_data;
        end
    end

    task automatic write_word(input fifo_word_t w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input int budget);
        logic done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !s_if.m_valid && !fifo_rd_en)
                done = 1'b1;
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_rd_en(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (fifo_rd_en) seen = 1'b1;
        end
        check("rd_en_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (s_if.m_valid) seen = 1'b1;
        end
        check("valid_seen", 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic       wr;
        fifo_word_t wdata;
        logic       en;
        logic       ready;
        logic       exp_rd;
        logic       exp_valid;
        fifo_word_t exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] base;
        int               r;
        int               v;
        int               run;

        // single word with backpressure, then en=0 behaviour
        tbl[0]  = '{1'b1, 16'h00A1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A1, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[7]  = '{1'b1, 16'h00B2, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00B2, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

        rst         = 1'b1;
        en          = 1'b1;
        clr_err     = 1'b0;
        force_uf    = 1'b0;
        s_if.m_ready = 1'b1;

        // reset with a preloaded FIFO
        for (int i = 0; i < 4; i++) write_word(fifo_word_t'(16'h0A01 + i));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_valid", 32'(s_if.m_valid), 32'd0);
            check("rst_data", 32'(s_if.m_data), 32'd0);
            check("rst_words_read", 32'(words_read), 32'd0);
            check("rst_err", 32'(underflow_err), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle(100);

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            en           = tbl[i].en;
            s_if.m_ready = tbl[i].ready;
            if (tbl[i].wr) write_word(tbl[i].wdata);
            @(negedge clk);
            check($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_valid", i), 32'(s_if.m_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_data", i), 32'(s_if.m_data), 32'(tbl[i].exp_data));
            check($sformatf("tbl%0d_err", i), 32'(underflow_err), 32'(tbl[i].exp_err));
        end
        @(posedge clk); #1;
        en = 1'b1;
        wait_idle(50);

        // 8-word stream at full rate
        base = cnt_exp;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) write_word(fifo_word_t'(i));
        r = -1;
        v = -1;
        run = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fifo_rd_en && r < 0) r = i;
            if (s_if.m_valid) begin
                if (v < 0) v = i;
                run++;
            end else if (v >= 0) begin
                break;
            end
        end
        check("first_word_latency", 32'(v - r), 32'd2);
        check("burst_len", 32'(run), 32'd8);
        check("words_read_after_burst", 32'(words_read), 32'(CNT_W'(base + CNT_W'(8))));

        // backpressure mid-stream
        wait_idle(50);
        @(posedge clk); #1;
        for (int i = 1; i <= 10; i++) write_word(fifo_word_t'(16'h0100 + i));
        wait_valid(20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(s_if.m_valid), 32'd1);
            if (i >= 1) check("stall_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        @(posedge clk); #1;
        s_if.m_ready = 1'b1;
        wait_idle(50);

        // underflow: drop, clear, set-wins
        @(posedge clk); #1;
        write_word(16'h0C01);
        wait_rd_en(20);
        @(posedge clk); #1;
        force_uf = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        force_uf = 1'b0;
        @(negedge clk);
        check("uf_err_set", 32'(underflow_err), 32'd1);
        check("uf_word_dropped", 32'(s_if.m_valid), 32'd0);
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(negedge clk);
        check("uf_err_before_clr_edge", 32'(underflow_err), 32'd1);
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("uf_err_cleared", 32'(underflow_err), 32'd0);

        @(posedge clk); #1;
        write_word(16'h0C02);
        wait_rd_en(20);
        @(posedge clk); #1;
        force_uf = 1'b1;
        clr_err  = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        force_uf = 1'b0;
        clr_err  = 1'b0;
        @(negedge clk);
        check("uf_set_wins", 32'(underflow_err), 32'd1);
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("uf_err_cleared2", 32'(underflow_err), 32'd0);

        // counter wrap from reset, then reset with a read in flight
        wait_idle(50);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) write_word(fifo_word_t'(16'h0200 + i));
        wait_idle(100);
        check("wrap_count", 32'(words_read), 32'd1);

        @(posedge clk); #1;
        write_word(16'h0D01);
        wait_rd_en(20);
        @(posedge clk); #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(s_if.m_valid), 32'd0);
            check("post_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        end
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
